// File: rtl/watchdog_ctrl.sv
// Byte-wide register front-end for the watchdog timer: splits bus accesses into
// watchdog lanes, guards writes behind a two-byte unlock key, and provides a kick command.
module watchdog_ctrl #(
    parameter int unsigned UNLOCK_WINDOW = 64,
    parameter logic [7:0]  KEY1          = 8'h55,
    parameter logic [7:0]  KEY2          = 8'hAA,
    parameter logic [7:0]  KICK          = 8'hA5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  addr,
    input  logic [7:0]  wdata,
    input  logic        wr,
    input  logic        rd,
    output logic [7:0]  rdata,
    input  logic [15:0] wd_counter_out,
    input  logic [15:0] wd_reload_out,
    input  logic [7:0]  wd_config_out,
    output logic [15:0] wd_counter_in,
    output logic [15:0] wd_reload_in,
    output logic [7:0]  wd_config_in,
    output logic [1:0]  wd_counter_write,
    output logic [1:0]  wd_reload_write,
    output logic        wd_config_write,
    output logic        unlocked,
    output logic        key_error
);

    // Encoding is architecturally visible through the KEY register read.
    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_KEY1     = 2'd1,
        ST_UNLOCKED = 2'd2
    } state_t;

    localparam logic [2:0] A_CNT_L  = 3'd0;
    localparam logic [2:0] A_CNT_H  = 3'd1;
    localparam logic [2:0] A_RLD_L  = 3'd2;
    localparam logic [2:0] A_RLD_H  = 3'd3;
    localparam logic [2:0] A_CFG    = 3'd4;
    localparam logic [2:0] A_KEY    = 3'd5;
    localparam logic [2:0] A_STATUS = 3'd6;

    localparam logic [7:0] WIN_LOAD = 8'(UNLOCK_WINDOW);

    state_t      state_q, state_d;
    logic [7:0]  win_q, win_d;
    logic        viol_q, viol_d;
    logic [7:0]  shadow_q, shadow_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [1:0]  cnt_wr_q, cnt_wr_d;
    logic [15:0] cnt_in_q, cnt_in_d;
    logic [1:0]  rld_wr_q, rld_wr_d;
    logic [15:0] rld_in_q, rld_in_d;
    logic        cfg_wr_q, cfg_wr_d;
    logic [7:0]  cfg_in_q, cfg_in_d;
    logic        key_err_q, key_err_d;
    logic        viol_set, viol_clr;

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        viol_d    = viol_q;
        shadow_d  = shadow_q;
        rdata_d   = rdata_q;
        cnt_wr_d  = 2'b00;
        cnt_in_d  = 16'h0000;
        rld_wr_d  = 2'b00;
        rld_in_d  = 16'h0000;
        cfg_wr_d  = 1'b0;
        cfg_in_d  = 8'h00;
        key_err_d = 1'b0;
        viol_set  = 1'b0;
        viol_clr  = 1'b0;

        if (state_q != ST_LOCKED && win_q != 8'd0) begin
            win_d = win_q - 8'd1;
        end

        // Reads see pre-write state, so they only look at *_q values.
        if (rd) begin
            case (addr)
                A_CNT_L: begin
                    rdata_d  = wd_counter_out[7:0];
                    shadow_d = wd_counter_out[15:8];
                end
                A_CNT_H:  rdata_d = shadow_q;
                A_RLD_L:  rdata_d = wd_reload_out[7:0];
                A_RLD_H:  rdata_d = wd_reload_out[15:8];
                A_CFG:    rdata_d = wd_config_out;
                A_KEY:    rdata_d = {6'b0, state_q};
                A_STATUS: rdata_d = {7'b0, viol_q};
                default:  rdata_d = 8'h00;
            endcase
        end

        if (wr) begin
            case (addr)
                A_CNT_L, A_CNT_H, A_RLD_L, A_RLD_H, A_CFG: begin
                    if (state_q == ST_UNLOCKED) begin
                        case (addr)
                            A_CNT_L: begin cnt_wr_d = 2'b01; cnt_in_d[7:0]  = wdata; end
                            A_CNT_H: begin cnt_wr_d = 2'b10; cnt_in_d[15:8] = wdata; end
                            A_RLD_L: begin rld_wr_d = 2'b01; rld_in_d[7:0]  = wdata; end
                            A_RLD_H: begin rld_wr_d = 2'b10; rld_in_d[15:8] = wdata; end
                            default: begin
                                cfg_wr_d = 1'b1;
                                cfg_in_d = wdata;
                                state_d  = ST_LOCKED;
                            end
                        endcase
                    end else begin
                        key_err_d = 1'b1;
                        viol_set  = 1'b1;
                    end
                end
                A_KEY: begin
                    case (state_q)
                        ST_LOCKED: begin
                            if (wdata == KEY1) begin
                                state_d = ST_KEY1;
                                win_d   = WIN_LOAD;
                            end else if (wdata == KICK) begin
                                cnt_wr_d = 2'b11;
                                cnt_in_d = wd_reload_out;
                            end else begin
                                key_err_d = 1'b1;
                            end
                        end
                        ST_KEY1: begin
                            if (wdata == KEY2) begin
                                state_d = ST_UNLOCKED;
                                win_d   = WIN_LOAD;
                            end else begin
                                key_err_d = 1'b1;
                                state_d   = ST_LOCKED;
                            end
                        end
                        default: state_d = ST_LOCKED;
                    endcase
                end
                A_STATUS: viol_clr = wdata[0];
                default: ;
            endcase
        end

        // Window expiry overrides whatever the bus asked for this cycle.
        if (state_q != ST_LOCKED && win_q == 8'd0) begin
            state_d = ST_LOCKED;
        end
        if (state_d == ST_LOCKED) begin
            win_d = 8'd0;
        end

        if (viol_set) begin
            viol_d = 1'b1;
        end else if (viol_clr) begin
            viol_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_LOCKED;
            win_q     <= 8'd0;
            viol_q    <= 1'b0;
            shadow_q  <= 8'h00;
            rdata_q   <= 8'h00;
            cnt_wr_q  <= 2'b00;
            cnt_in_q  <= 16'h0000;
            rld_wr_q  <= 2'b00;
            rld_in_q  <= 16'h0000;
            cfg_wr_q  <= 1'b0;
            cfg_in_q  <= 8'h00;
            key_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            viol_q    <= viol_d;
            shadow_q  <= shadow_d;
            rdata_q   <= rdata_d;
            cnt_wr_q  <= cnt_wr_d;
            cnt_in_q  <= cnt_in_d;
            rld_wr_q  <= rld_wr_d;
            rld_in_q  <= rld_in_d;
            cfg_wr_q  <= cfg_wr_d;
            cfg_in_q  <= cfg_in_d;
            key_err_q <= key_err_d;
        end
    end

    assign rdata            = rdata_q;
    assign wd_counter_write = cnt_wr_q;
    assign wd_counter_in    = cnt_in_q;
    assign wd_reload_write  = rld_wr_q;
    assign wd_reload_in     = rld_in_q;
    assign wd_config_write  = cfg_wr_q;
    assign wd_config_in     = cfg_in_q;
    assign key_error        = key_err_q;
    assign unlocked         = (state_q == ST_UNLOCKED);

endmodule
